// File: rtl/fwrisc_mds_lockstep_checker.sv
// Lockstep checker for NUM_LANES replicas of the FWRISC mul/div/shift unit; lane 0 is golden.
// Optional first-failure capture outputs are enabled by defining FWRISC_MDS_CHK_CAPTURE_EN.
module fwrisc_mds_lockstep_checker #(
   parameter int NUM_LANES = 2,
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int MAX_OUT   = 4,
   parameter int TIMEOUT   = 64,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic [NUM_LANES-1:0]         in_valid,
   input  logic [NUM_LANES-1:0]         res_valid,
   input  logic [NUM_LANES*WIDTH-1:0]   res_data,
   output logic                         cmp_valid,
   output logic                         cmp_equal,
   output logic                         mismatch,
   output logic [NUM_LANES-1:0]         mismatch_lanes,
   output logic                         proto_err,
   output logic                         timeout,
   output logic [CNT_W-1:0]             cmp_count
`ifdef FWRISC_MDS_CHK_CAPTURE_EN
   ,
   output logic [NUM_LANES*WIDTH-1:0]   first_bad_data,
   output logic [CNT_W-1:0]             first_bad_idx
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
   localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

   logic [WIDTH-1:0]                mem_q [NUM_LANES][DEPTH];
   logic [NUM_LANES-1:0][AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NUM_LANES-1:0][OW-1:0]    out_q, out_d;
   logic [NUM_LANES-1:0][IW-1:0]    idle_q, idle_d;
   logic                            cmp_valid_q, cmp_valid_d, cmp_equal_q, cmp_equal_d;
   logic                            mismatch_q, mismatch_d, proto_q, proto_d, timeout_q, timeout_d;
   logic [NUM_LANES-1:0]            mm_lanes_q, mm_lanes_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;

   logic [NUM_LANES-1:0]            empty_s, full_s, push_s, diff_s;
   logic [NUM_LANES*WIDTH-1:0]      heads_s;
   logic                            pop_s, proto_ev_s, timeout_ev_s;

   // FIFO status and heads; all lanes pop together only when every FIFO holds a result.
   always_comb begin
      pop_s = 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
         empty_s[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full_s[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                      (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
         heads_s[i*WIDTH +: WIDTH] = mem_q[i][rd_ptr_q[i][AW-1:0]];
         pop_s = pop_s & ~empty_s[i];
      end
   end

   // Per-lane difference against the golden head; lane 0 never differs from itself.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         diff_s[i] = (heads_s[i*WIDTH +: WIDTH] != heads_s[WIDTH-1:0]);
      end
   end

   // Pointer, outstanding and idle next-state, plus protocol/timeout events.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      out_d        = out_q;
      idle_d       = idle_q;
      push_s       = '0;
      proto_ev_s   = 1'b0;
      timeout_ev_s = 1'b0;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         out_d    = '0;
         idle_d   = '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            // A full FIFO still accepts when the common pop frees a slot this cycle.
            push_s[i]  = res_valid[i] & (~full_s[i] | pop_s);
            proto_ev_s = proto_ev_s | (res_valid[i] & full_s[i] & ~pop_s);
            if (push_s[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            else           wr_ptr_d[i] = wr_ptr_q[i];
            if (pop_s) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            else       rd_ptr_d[i] = rd_ptr_q[i];
            if (in_valid[i] && !res_valid[i]) begin
               if (out_q[i] == MAX_OUT_C) proto_ev_s = 1'b1;
               else                       out_d[i]   = out_q[i] + 1'b1;
            end else if (!in_valid[i] && res_valid[i]) begin
               if (out_q[i] == '0) proto_ev_s = 1'b1;
               else                out_d[i]   = out_q[i] - 1'b1;
            end else begin
               out_d[i] = out_q[i];
            end
            if (res_valid[i] || out_q[i] == '0) idle_d[i] = '0;
            else if (idle_q[i] == TIMEOUT_C)    idle_d[i] = idle_q[i];
            else                                idle_d[i] = idle_q[i] + 1'b1;
            if (idle_d[i] == TIMEOUT_C) timeout_ev_s = 1'b1;
            else                        timeout_ev_s = timeout_ev_s;
         end
      end
   end

   // Registered comparison result and sticky flags.
   always_comb begin
      cmp_valid_d = 1'b0;
      cmp_equal_d = 1'b0;
      mismatch_d  = mismatch_q;
      mm_lanes_d  = mm_lanes_q;
      proto_d     = proto_q;
      timeout_d   = timeout_q;
      cnt_d       = cnt_q;
      if (clear) begin
         mismatch_d = 1'b0;
         mm_lanes_d = '0;
         proto_d    = 1'b0;
         timeout_d  = 1'b0;
         cnt_d      = '0;
      end else begin
         cmp_valid_d = pop_s;
         cmp_equal_d = pop_s && (diff_s == '0);
         if (pop_s) begin
            mismatch_d = mismatch_q | (diff_s != '0);
            mm_lanes_d = mm_lanes_q | diff_s;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            else             cnt_d = cnt_q;
         end else begin
            mismatch_d = mismatch_q;
            mm_lanes_d = mm_lanes_q;
         end
         proto_d   = proto_q | proto_ev_s;
         timeout_d = timeout_q | timeout_ev_s;
      end
   end

   // Result storage; occupancy is defined by the pointers alone, so contents need no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (push_s[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= res_data[i*WIDTH +: WIDTH];
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_q       <= '0;
         idle_q      <= '0;
         cmp_valid_q <= 1'b0;
         cmp_equal_q <= 1'b0;
         mismatch_q  <= 1'b0;
         mm_lanes_q  <= '0;
         proto_q     <= 1'b0;
         timeout_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_q       <= out_d;
         idle_q      <= idle_d;
         cmp_valid_q <= cmp_valid_d;
         cmp_equal_q <= cmp_equal_d;
         mismatch_q  <= mismatch_d;
         mm_lanes_q  <= mm_lanes_d;
         proto_q     <= proto_d;
         timeout_q   <= timeout_d;
         cnt_q       <= cnt_d;
      end
   end

   assign cmp_valid      = cmp_valid_q;
   assign cmp_equal      = cmp_equal_q;
   assign mismatch       = mismatch_q;
   assign mismatch_lanes = mm_lanes_q;
   assign proto_err      = proto_q;
   assign timeout        = timeout_q;
   assign cmp_count      = cnt_q;

`ifdef FWRISC_MDS_CHK_CAPTURE_EN
   logic [NUM_LANES*WIDTH-1:0] fb_data_q, fb_data_d;
   logic [CNT_W-1:0]           fb_idx_q, fb_idx_d;

   // Snapshot only the first failing compare; the clear mismatch flag marks "not yet captured".
   always_comb begin
      fb_data_d = fb_data_q;
      fb_idx_d  = fb_idx_q;
      if (clear) begin
         fb_data_d = '0;
         fb_idx_d  = '0;
      end else if (pop_s && (diff_s != '0) && !mismatch_q) begin
         fb_data_d = heads_s;
         fb_idx_d  = cnt_q;
      end else begin
         fb_data_d = fb_data_q;
         fb_idx_d  = fb_idx_q;
      end
   end

   // Capture registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fb_data_q <= '0;
         fb_idx_q  <= '0;
      end else begin
         fb_data_q <= fb_data_d;
         fb_idx_q  <= fb_idx_d;
      end
   end

   assign first_bad_data = fb_data_q;
   assign first_bad_idx  = fb_idx_q;
`endif
endmodule
